// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, valid/ready
// handshake on both sides, runtime signed/unsigned selection via tc.
// Optional build macro MUL_BOOTH_SEQ_EARLY_TERM_EN: leave CALC as soon as
// every remaining Booth digit is zero (result unchanged, latency 1..ITER).
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | one Booth iteration per cycle over the extended multiplier
// DONE  | out_valid=1, product held until out_ready
module mul_booth_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int BW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [BW-1:0]      b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [AW-1:0]      term;
  logic [AW-1:0]      acc_next;
  logic               last;
  logic               a_sgn, b_sgn;

  // Booth digit decode on the low three bits of the multiplier window
  // ({b[2i+1], b[2i], b[2i-1]}); a_q already carries the 2i shift.
  always_comb begin
    term = '0;
    unique case (b_q[2:0])
      3'b001, 3'b010: term = a_q;
      3'b011:         term = a_q << 1;
      3'b100:         term = -(a_q << 1);
      3'b101, 3'b110: term = -a_q;
      default:        term = '0;
    endcase
    acc_next = acc_q + term;
  end

  // Last-iteration detect. The multiplier shifts in copies of its top bit, so
  // "all remaining bits equal the overlap bit" is "window above bit 1 is uniform".
  always_comb begin
`ifdef MUL_BOOTH_SEQ_EARLY_TERM_EN
    last = (cnt_q == CW'(ITER - 1)) || (&b_q[BW-1:2]) || !(|b_q[BW-1:2]);
`else
    last = (cnt_q == CW'(ITER - 1));
`endif
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    a_sgn     = tc & a[WIDTH-1];
    b_sgn     = tc & b[WIDTH-1];
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{(AW - WIDTH){a_sgn}}, a};
          b_d     = {{2{b_sgn}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        a_d   = a_q << 2;
        b_d   = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          product_d = acc_next[2*WIDTH-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    product   = product_q;
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Directed and random checks of mul_booth_seq at WIDTH=16.
module tb_mul_booth_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        tc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  mul_booth_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, measure edges from accept to out_valid, then retire it.
  task automatic do_op(input logic tc_i, input logic [15:0] a_i, input logic [15:0] b_i,
                       output logic [31:0] prod, output int lat);
    @(negedge clk);
    tc = tc_i; a = a_i; b = b_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = product;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; tc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (product !== 32'h0) begin n_fail++; $display("FAIL reset_product got %h want 0", product); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] p;
    int lat;
    do_op(1'b1, 16'hFFFF, 16'hFFFF, p, lat);
    n_checks++; if (p !== 32'h00000001) begin n_fail++; $display("FAIL s_m1xm1 got %h want 00000001", p); end
`ifndef MUL_BOOTH_SEQ_EARLY_TERM_EN
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL s_m1xm1_latency got %0d want 9", lat); end
`endif
    do_op(1'b0, 16'hFFFF, 16'hFFFF, p, lat);
    n_checks++; if (p !== 32'hFFFE0001) begin n_fail++; $display("FAIL u_ffffxffff got %h want FFFE0001", p); end
    do_op(1'b1, 16'h8000, 16'h8000, p, lat);
    n_checks++; if (p !== 32'h40000000) begin n_fail++; $display("FAIL s_minxmin got %h want 40000000", p); end
    do_op(1'b1, 16'h8000, 16'h7FFF, p, lat);
    n_checks++; if (p !== 32'hC0008000) begin n_fail++; $display("FAIL s_minxmax got %h want C0008000", p); end
    do_op(1'b0, 16'h8000, 16'h8000, p, lat);
    n_checks++; if (p !== 32'h40000000) begin n_fail++; $display("FAIL u_8000x8000 got %h want 40000000", p); end
  endtask

  task automatic test_early_term;
    logic [31:0] p;
    int lat;
    int exp_lat3, exp_lat0;
`ifdef MUL_BOOTH_SEQ_EARLY_TERM_EN
    exp_lat3 = 2; exp_lat0 = 1;
`else
    exp_lat3 = 9; exp_lat0 = 9;
`endif
    do_op(1'b1, 16'd100, 16'd3, p, lat);
    n_checks++; if (p !== 32'd300) begin n_fail++; $display("FAIL et_100x3 got %h want 0000012c", p); end
    n_checks++; if (lat !== exp_lat3) begin n_fail++; $display("FAIL et_100x3_latency got %0d want %0d", lat, exp_lat3); end
    do_op(1'b1, 16'h1234, 16'h0000, p, lat);
    n_checks++; if (p !== 32'd0) begin n_fail++; $display("FAIL et_bzero got %h want 0", p); end
    n_checks++; if (lat !== exp_lat0) begin n_fail++; $display("FAIL et_bzero_latency got %0d want %0d", lat, exp_lat0); end
  endtask

  task automatic test_back_pressure;
    logic [31:0] p, held;
    int lat;
    @(negedge clk);
    tc = 1'b0; a = 16'd300; b = 16'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    tc = 1'b1; a = 16'hFFFF; b = 16'h0005;   // ignored while busy
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    held = product;
    n_checks++; if (held !== 32'd60000) begin n_fail++; $display("FAIL bp_product got %h want 0000ea60", held); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || product !== 32'd60000 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got ov=%b p=%h ir=%b want ov=1 p=0000ea60 ir=0", i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    do_op(1'b1, 16'hFFF9, 16'd6, p, lat);
    n_checks++; if (p !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL b2b_product got %h want FFFFFFD6", p); end
  endtask

  task automatic test_out_ready_high;
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    tc = 1'b1; a = 16'd1000; b = 16'hFFFE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (product !== 32'hFFFFF830) begin n_fail++; $display("FAIL orh_product got %h want FFFFF830", product); end
`ifndef MUL_BOOTH_SEQ_EARLY_TERM_EN
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL orh_latency got %0d want 9", lat); end
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL orh_retire got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] p;
    int lat;
    @(negedge clk);
    tc = 1'b0; a = 16'd7; b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || product !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got ov=%b p=%h ir=%b want ov=0 p=0 ir=1", out_valid, product, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(1'b1, 16'hFFF9, 16'd6, p, lat);
    n_checks++; if (p !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL post_reset got %h want FFFFFFD6", p); end
  endtask

  task automatic test_random;
    logic [31:0] p, exp;
    logic [15:0] ra, rb;
    logic        rt;
    longint      sa, sb;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rt = 1'($urandom);
      sa = rt ? longint'($signed(ra)) : longint'(ra);
      sb = rt ? longint'($signed(rb)) : longint'(rb);
      exp = 32'(sa * sb);
      do_op(rt, ra, rb, p, lat);
      n_checks++; if (p !== exp) begin
        n_fail++; $display("FAIL rand_%0d tc=%b a=%h b=%h got %h want %h", i, rt, ra, rb, p, exp);
      end
`ifndef MUL_BOOTH_SEQ_EARLY_TERM_EN
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL rand_latency_%0d got %0d want 9", i, lat); end
`else
      n_checks++; if (lat < 1 || lat > 9) begin n_fail++; $display("FAIL rand_latency_%0d got %0d want 1..9", i, lat); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_early_term();
    test_back_pressure();
    test_out_ready_high();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
